aemb_fsl_resp: RTL and testbench
================================

Name: aemb_fsl_resp

Overview:
- FSL responder: the slave end of the aeMB core's FSL GET/PUT bus, for one channel address.
- PUT transactions from the core push {ctl, data} into a transmit FIFO, which drains to a valid/ready output stream.
- A valid/ready input stream fills a receive FIFO, and GET transactions pop from it.
- Sits beside the core and drives fsl_ack/fsl_dat back to it; several instances with different CHN values may share one FSL bus.

Parameters:
CHN, 0, FSL channel address (5 bits) this instance answers; compared against fsl_adr_i[6:2]
AW, 4, log2 FIFO depth; each FIFO holds 2**AW entries of 33 bits {ctl, dat[31:0]}

Ports:
sys_clk_i  in  1  clock, rising edge
sys_rst_i  in  1  asynchronous reset, active-low
fsl_stb_i  in  1  transaction strobe from core; held until acked
fsl_wre_i  in  1  1 = PUT (core writes), 0 = GET (core reads)
fsl_adr_i  in  5  [6:2] channel address
fsl_tag_i  in  2  [1] control flag, [0] non-blocking
fsl_dat_i  in  32  PUT data
fsl_ack_o  out  1  single-cycle completion pulse
fsl_dat_o  out  32  GET data, valid while fsl_ack_o=1
put_dat_o  out  32  transmit stream data (FIFO head)
put_ctl_o  out  1  transmit stream control flag
put_vld_o  out  1  transmit stream valid
put_rdy_i  in  1  transmit stream ready
get_dat_i  in  32  receive stream data
get_ctl_i  in  1  receive stream control flag
get_vld_i  in  1  receive stream valid
get_rdy_o  out  1  receive stream ready
get_ctl_o  out  1  control flag of the last GET word, valid with fsl_ack_o

Behaviour:
- Reset values: all outputs 0, FIFOs empty, FSM in IDLE. Reset may assert mid-transaction; the pending transaction is abandoned with no ack and FIFO contents are lost.
- get_rdy_o is 0 during reset and rises the first clock after release.
- hit = fsl_stb_i & (fsl_adr_i == CHN). A strobe that does not hit is ignored: no ack, no state change.
- FSM has two states.
- IDLE, hit & PUT:
  - Transmit FIFO not full: push {tag[1], dat}, go to ACK.
  - Transmit FIFO full and tag[0]=0 (blocking): stay in IDLE; the core stalls.
  - Transmit FIFO full and tag[0]=1 (non-blocking): drop the word, go to ACK.
- IDLE, hit & GET:
  - Receive FIFO not empty: pop, register the head into fsl_dat_o/get_ctl_o, go to ACK.
  - Receive FIFO empty and blocking: wait in IDLE.
  - Receive FIFO empty and non-blocking: load fsl_dat_o = 0 and get_ctl_o = 0, go to ACK.
- ACK: fsl_ack_o=1 for exactly one cycle, then unconditionally return to IDLE.
  - The still-high strobe seen during ACK is not re-sampled.
  - A back-to-back strobe is evaluated in the following IDLE cycle.
- Latency: the earliest ack is the cycle after the hit is first sampled (1-cycle ack). A stalled transaction acks the cycle after the FIFO condition clears.
- fsl_dat_o and get_ctl_o hold their value after the ack until the next GET completes.
- Transmit stream is first-word fall-through:
  - put_vld_o = !empty, with put_dat_o/put_ctl_o equal to the head entry.
  - Pop on put_vld_o & put_rdy_i.
  - Head data must stay stable while valid and not ready.
- Receive stream: get_rdy_o = !full, registered so it is 0 during reset. Push on get_vld_i & get_rdy_o.
- FIFO rules:
  - Read/write pointers are AW+1 bits and wrap modulo 2**(AW+1).
  - full = (MSBs differ and lower bits equal); empty = pointers equal.
  - Simultaneous push and pop leaves the count unchanged.
  - Push is refused when full, even with a same-cycle pop (no bypass).
  - Pop is refused when empty, even with a same-cycle push (no fall-through bypass).
- fsl_tag_i[1] on a GET is ignored; fsl_dat_i on a GET is ignored.

Decomposition:
- Shared package: FSL tag bit indices (TAG_CTL=1, TAG_NB=0), FSM state encoding (IDLE, ACK), channel width constant 5.
- One sub-module: aemb_fsl_fifo.
  - Parameter AW; width 33.
  - Ports: clock, reset, push, push data, pop, head data, full, empty.
  - Instantiated twice (transmit, receive).

Test Plan:
- Blocking PUT, CHN=3, adr=3, dat=0xDEADBEEF, tag=2'b10 -> ack one cycle after stb; put_vld_o=1 with put_dat_o=0xDEADBEEF and put_ctl_o=1 next cycle; pops when put_rdy_i=1.
- Fill transmit FIFO with 16 blocking PUTs (AW=4), put_rdy_i=0, then a 17th PUT -> no ack; raise put_rdy_i for 1 cycle -> 17th acked next cycle; order 1..17 preserved on stream.
- Non-blocking GET on empty receive FIFO (tag=2'b01) -> ack after 1 cycle with fsl_dat_o=0 and get_ctl_o=0; blocking GET -> stalls until get_vld_i delivers 0x12345678 with ctl=1, then acks with those values.
- Back-to-back PUT, GET, PUT with stb held high continuously -> exactly three single-cycle acks, no double push.
- Strobe with adr=5 while CHN=3 -> fsl_ack_o stays 0 for 20 cycles and FIFO levels are unchanged.
- Assert sys_rst_i low while a blocking GET is stalled with 3 words in the transmit FIFO -> ack never fires, put_vld_o=0, get_rdy_o=0 during reset and 1 the first cycle after release.

Source files
------------

// File: rtl/aemb_fsl_resp_pkg.sv
// Shared definitions for the aeMB FSL responder: tag bit positions, channel width and FSM states.
package aemb_fsl_resp_pkg;

  localparam int unsigned CHN_W = 5;

  // Single-bit typed so they index a 2-bit tag without width surprises.
  localparam logic TAG_CTL = 1'b1;
  localparam logic TAG_NB  = 1'b0;

  localparam int unsigned DAT_W = 32;
  localparam int unsigned ENT_W = DAT_W + 1;

  typedef enum logic [0:0] {
    StIdle,
    StAck
  } fsl_state_e;

  function automatic logic chn_hit(input logic stb, input logic [CHN_W-1:0] adr,
                                   input logic [CHN_W-1:0] chn);
    return stb && (adr == chn);
  endfunction

endpackage

// File: rtl/aemb_fsl_fifo.sv
// Synchronous FIFO with AW+1 bit wrap pointers; refuses push when full and pop when empty.
module aemb_fsl_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned W  = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int unsigned Depth = 2 ** AW;

  logic [W-1:0] mem [Depth];
  logic [AW:0]  wptr_q, rptr_q;
  logic         do_push, do_pop;

  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/aemb_fsl_resp.sv
// FSL slave for one channel: PUTs feed a transmit FIFO/stream, GETs drain a receive FIFO/stream.
module aemb_fsl_resp
  import aemb_fsl_resp_pkg::*;
#(
  parameter logic [CHN_W-1:0] CHN = 5'd0,
  parameter int unsigned      AW  = 4
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             fsl_stb_i,
  input  logic             fsl_wre_i,
  input  logic [CHN_W-1:0] fsl_adr_i,
  input  logic [1:0]       fsl_tag_i,
  input  logic [DAT_W-1:0] fsl_dat_i,
  output logic             fsl_ack_o,
  output logic [DAT_W-1:0] fsl_dat_o,
  output logic [DAT_W-1:0] put_dat_o,
  output logic             put_ctl_o,
  output logic             put_vld_o,
  input  logic             put_rdy_i,
  input  logic [DAT_W-1:0] get_dat_i,
  input  logic             get_ctl_i,
  input  logic             get_vld_i,
  output logic             get_rdy_o,
  output logic             get_ctl_o
);

  fsl_state_e       state_q, state_d;
  logic             hit;
  logic             tx_push, tx_pop, tx_full, tx_empty;
  logic             rx_push, rx_pop, rx_full, rx_empty;
  logic [ENT_W-1:0] tx_head, rx_head;
  logic [DAT_W-1:0] gdat_q, gdat_d;
  logic             gctl_q, gctl_d;
  logic             rdy_q;

  assign hit = chn_hit(fsl_stb_i, fsl_adr_i, CHN);

  aemb_fsl_fifo #(
    .AW (AW),
    .W  (ENT_W)
  ) u_tx_fifo (
    .clk      (sys_clk_i),
    .rst_n    (sys_rst_i),
    .push     (tx_push),
    .push_dat ({fsl_tag_i[TAG_CTL], fsl_dat_i}),
    .pop      (tx_pop),
    .head     (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  aemb_fsl_fifo #(
    .AW (AW),
    .W  (ENT_W)
  ) u_rx_fifo (
    .clk      (sys_clk_i),
    .rst_n    (sys_rst_i),
    .push     (rx_push),
    .push_dat ({get_ctl_i, get_dat_i}),
    .pop      (rx_pop),
    .head     (rx_head),
    .full     (rx_full),
    .empty    (rx_empty)
  );

  always_comb begin
    state_d = state_q;
    tx_push = 1'b0;
    rx_pop  = 1'b0;
    gdat_d  = gdat_q;
    gctl_d  = gctl_q;
    case (state_q)
      StIdle: begin
        if (hit) begin
          if (fsl_wre_i) begin
            if (!tx_full) begin
              tx_push = 1'b1;
              state_d = StAck;
            end else if (fsl_tag_i[TAG_NB]) begin
              state_d = StAck;
            end
          end else begin
            if (!rx_empty) begin
              rx_pop  = 1'b1;
              gdat_d  = rx_head[DAT_W-1:0];
              gctl_d  = rx_head[DAT_W];
              state_d = StAck;
            end else if (fsl_tag_i[TAG_NB]) begin
              gdat_d  = '0;
              gctl_d  = 1'b0;
              state_d = StAck;
            end
          end
        end
      end
      // The strobe is still high here but belongs to the finished transaction.
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      state_q <= StIdle;
      gdat_q  <= '0;
      gctl_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gdat_q  <= gdat_d;
      gctl_q  <= gctl_d;
      rdy_q   <= 1'b1;
    end
  end

  assign fsl_ack_o = (state_q == StAck);
  assign fsl_dat_o = gdat_q;
  assign get_ctl_o = gctl_q;

  // Head is masked while empty so stale storage never shows on the stream.
  assign put_vld_o = !tx_empty;
  assign put_dat_o = put_vld_o ? tx_head[DAT_W-1:0] : '0;
  assign put_ctl_o = put_vld_o && tx_head[DAT_W];
  assign tx_pop    = put_vld_o && put_rdy_i;

  assign get_rdy_o = rdy_q && !rx_full;
  assign rx_push   = get_vld_i && get_rdy_o;

endmodule

// File: tb/tb_aemb_fsl_resp.sv
// Bench for aemb_fsl_resp: vector table, corner-case sequences and a queue-based random model.
module tb_aemb_fsl_resp;

  localparam logic [4:0] CHN   = 5'd3;
  localparam int         AW    = 4;
  localparam int         DEPTH = 16;

  logic        sys_clk_i = 1'b0;
  logic        sys_rst_i = 1'b0;
  logic        fsl_stb_i = 1'b0;
  logic        fsl_wre_i = 1'b0;
  logic [4:0]  fsl_adr_i = '0;
  logic [1:0]  fsl_tag_i = '0;
  logic [31:0] fsl_dat_i = '0;
  logic        fsl_ack_o;
  logic [31:0] fsl_dat_o;
  logic [31:0] put_dat_o;
  logic        put_ctl_o;
  logic        put_vld_o;
  logic        put_rdy_i = 1'b0;
  logic [31:0] get_dat_i = '0;
  logic        get_ctl_i = 1'b0;
  logic        get_vld_i = 1'b0;
  logic        get_rdy_o;
  logic        get_ctl_o;

  int checks = 0;
  int errors = 0;

  aemb_fsl_resp #(
    .CHN (CHN),
    .AW  (AW)
  ) dut (
    .sys_clk_i (sys_clk_i),
    .sys_rst_i (sys_rst_i),
    .fsl_stb_i (fsl_stb_i),
    .fsl_wre_i (fsl_wre_i),
    .fsl_adr_i (fsl_adr_i),
    .fsl_tag_i (fsl_tag_i),
    .fsl_dat_i (fsl_dat_i),
    .fsl_ack_o (fsl_ack_o),
    .fsl_dat_o (fsl_dat_o),
    .put_dat_o (put_dat_o),
    .put_ctl_o (put_ctl_o),
    .put_vld_o (put_vld_o),
    .put_rdy_i (put_rdy_i),
    .get_dat_i (get_dat_i),
    .get_ctl_i (get_ctl_i),
    .get_vld_i (get_vld_i),
    .get_rdy_o (get_rdy_o),
    .get_ctl_o (get_ctl_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge sys_clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst_i = 1'b0;
    fsl_stb_i = 1'b0;
    put_rdy_i = 1'b0;
    get_vld_i = 1'b0;
    repeat (3) tick();
    sys_rst_i = 1'b1;
    tick();
  endtask

  // Runs one transaction; lat = ticks until ack, 0 if none within budget.
  task automatic xfer(input logic wre, input logic [4:0] adr, input logic [1:0] tag,
                      input logic [31:0] dat, input int budget, output int lat,
                      output logic [31:0] rdat, output logic rctl);
    lat  = 0;
    rdat = '0;
    rctl = 1'b0;
    fsl_stb_i = 1'b1;
    fsl_wre_i = wre;
    fsl_adr_i = adr;
    fsl_tag_i = tag;
    fsl_dat_i = dat;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (fsl_ack_o) begin
        lat  = i;
        rdat = fsl_dat_o;
        rctl = get_ctl_o;
        break;
      end
    end
    fsl_stb_i = 1'b0;
    tick();
    if (lat != 0) chk("ack_single_cycle", 64'(fsl_ack_o), 64'(0));
  endtask

  task automatic pop_tx(input logic [31:0] exp_dat, input logic exp_ctl);
    chk("tx_vld", 64'(put_vld_o), 64'(1));
    chk("tx_dat", 64'(put_dat_o), 64'(exp_dat));
    chk("tx_ctl", 64'(put_ctl_o), 64'(exp_ctl));
    put_rdy_i = 1'b1;
    tick();
    put_rdy_i = 1'b0;
  endtask

  task automatic push_rx(input logic [31:0] dat, input logic ctl);
    get_dat_i = dat;
    get_ctl_i = ctl;
    get_vld_i = 1'b1;
    tick();
    get_vld_i = 1'b0;
  endtask

  typedef struct {
    logic        wre;
    logic [4:0]  adr;
    logic [1:0]  tag;
    logic [31:0] dat;
    int          exp_lat;
    logic [31:0] exp_rdat;
    logic        exp_rctl;
    logic        exp_pvld;
    logic [31:0] exp_pdat;
    logic        exp_pctl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int          lat;
    logic [31:0] rdat;
    logic        rctl;
    int          nacks;
    logic        stall_ack, prev_ack, dbl;
    logic [31:0] b2b_dat;
    logic [32:0] txq[$];
    logic [32:0] rxq[$];
    logic [32:0] ent;

    vecs[0] = '{1'b1, 5'd3, 2'b10, 32'hDEADBEEF, 1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[1] = '{1'b1, 5'd3, 2'b00, 32'h11111111, 1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[2] = '{1'b1, 5'd5, 2'b00, 32'h22222222, 0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[3] = '{1'b0, 5'd3, 2'b01, 32'hFFFFFFFF, 1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[4] = '{1'b0, 5'd3, 2'b11, 32'h0,        1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[5] = '{1'b0, 5'd5, 2'b01, 32'h0,        0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[6] = '{1'b1, 5'd3, 2'b11, 32'h33333333, 1, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vecs[7] = '{1'b0, 5'd3, 2'b00, 32'h0,        0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};

    // Reset values
    sys_rst_i = 1'b0;
    repeat (3) tick();
    chk("rst_ack", 64'(fsl_ack_o), 64'(0));
    chk("rst_fsl_dat", 64'(fsl_dat_o), 64'(0));
    chk("rst_get_ctl", 64'(get_ctl_o), 64'(0));
    chk("rst_put_vld", 64'(put_vld_o), 64'(0));
    chk("rst_put_dat", 64'(put_dat_o), 64'(0));
    chk("rst_put_ctl", 64'(put_ctl_o), 64'(0));
    chk("rst_get_rdy", 64'(get_rdy_o), 64'(0));
    sys_rst_i = 1'b1;
    tick();
    chk("rdy_after_release", 64'(get_rdy_o), 64'(1));

    // Vector table (20-cycle budget covers the wrong-address and stalled cases)
    foreach (vecs[i]) begin
      xfer(vecs[i].wre, vecs[i].adr, vecs[i].tag, vecs[i].dat, 20, lat, rdat, rctl);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].exp_lat));
      if (!vecs[i].wre && vecs[i].exp_lat != 0) begin
        chk($sformatf("vec%0d_rdat", i), 64'(rdat), 64'(vecs[i].exp_rdat));
        chk($sformatf("vec%0d_rctl", i), 64'(rctl), 64'(vecs[i].exp_rctl));
      end
      chk($sformatf("vec%0d_pvld", i), 64'(put_vld_o), 64'(vecs[i].exp_pvld));
      chk($sformatf("vec%0d_pdat", i), 64'(put_dat_o), 64'(vecs[i].exp_pdat));
      chk($sformatf("vec%0d_pctl", i), 64'(put_ctl_o), 64'(vecs[i].exp_pctl));
    end
    pop_tx(32'hDEADBEEF, 1'b1);
    pop_tx(32'h11111111, 1'b0);
    pop_tx(32'h33333333, 1'b1);
    chk("vec_tx_drained", 64'(put_vld_o), 64'(0));

    // Fill transmit FIFO, 17th PUT stalls until one word drains
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      xfer(1'b1, CHN, 2'b00, 32'(i), 5, lat, rdat, rctl);
      chk($sformatf("fill%0d_lat", i), 64'(lat), 64'(1));
    end
    fsl_stb_i = 1'b1;
    fsl_wre_i = 1'b1;
    fsl_adr_i = CHN;
    fsl_tag_i = 2'b00;
    fsl_dat_i = 32'd17;
    stall_ack = 1'b0;
    repeat (5) begin
      tick();
      stall_ack |= fsl_ack_o;
    end
    chk("full_put_stalls", 64'(stall_ack), 64'(0));
    chk("full_head", 64'(put_dat_o), 64'(1));
    put_rdy_i = 1'b1;
    tick();
    put_rdy_i = 1'b0;
    lat = 0;
    for (int i = 1; i <= 5; i++) begin
      if (fsl_ack_o) begin
        lat = i;
        break;
      end
      tick();
    end
    chk("full_put_release_lat", 64'(lat), 64'(2));
    fsl_stb_i = 1'b0;
    tick();
    for (int i = 2; i <= 17; i++) pop_tx(32'(i), 1'b0);
    chk("full_drained", 64'(put_vld_o), 64'(0));

    // Blocking GET on empty receive FIFO stalls until a stream word arrives
    do_reset();
    fsl_stb_i = 1'b1;
    fsl_wre_i = 1'b0;
    fsl_adr_i = CHN;
    fsl_tag_i = 2'b00;
    stall_ack = 1'b0;
    repeat (4) begin
      tick();
      stall_ack |= fsl_ack_o;
    end
    chk("get_stalls", 64'(stall_ack), 64'(0));
    chk("get_rdy_empty", 64'(get_rdy_o), 64'(1));
    push_rx(32'h12345678, 1'b1);
    lat = 0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (fsl_ack_o) begin
        lat = i;
        break;
      end
    end
    chk("get_release_lat", 64'(lat), 64'(1));
    chk("get_release_dat", 64'(fsl_dat_o), 64'(32'h12345678));
    chk("get_release_ctl", 64'(get_ctl_o), 64'(1));
    fsl_stb_i = 1'b0;
    repeat (3) tick();
    chk("get_hold_dat", 64'(fsl_dat_o), 64'(32'h12345678));
    chk("get_hold_ctl", 64'(get_ctl_o), 64'(1));

    // Back-to-back PUT, GET, PUT with strobe held high
    do_reset();
    push_rx(32'hCAFE0001, 1'b0);
    fsl_stb_i = 1'b1;
    fsl_wre_i = 1'b1;
    fsl_adr_i = CHN;
    fsl_tag_i = 2'b00;
    fsl_dat_i = 32'hA5A50001;
    nacks    = 0;
    prev_ack = 1'b0;
    dbl      = 1'b0;
    b2b_dat  = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (fsl_ack_o && prev_ack) dbl = 1'b1;
      prev_ack = fsl_ack_o;
      if (fsl_ack_o) begin
        nacks++;
        if (nacks == 1) begin
          fsl_wre_i = 1'b0;
        end else if (nacks == 2) begin
          b2b_dat   = fsl_dat_o;
          fsl_wre_i = 1'b1;
          fsl_tag_i = 2'b10;
          fsl_dat_i = 32'h5A5A0002;
        end else begin
          fsl_stb_i = 1'b0;
        end
      end
    end
    chk("b2b_acks", 64'(nacks), 64'(3));
    chk("b2b_no_double", 64'(dbl), 64'(0));
    chk("b2b_get_dat", 64'(b2b_dat), 64'(32'hCAFE0001));
    pop_tx(32'hA5A50001, 1'b0);
    pop_tx(32'h5A5A0002, 1'b1);
    chk("b2b_tx_drained", 64'(put_vld_o), 64'(0));

    // Reset while a blocking GET stalls with three words queued
    do_reset();
    for (int i = 0; i < 3; i++) xfer(1'b1, CHN, 2'b00, 32'(100 + i), 5, lat, rdat, rctl);
    chk("rstmid_vld_before", 64'(put_vld_o), 64'(1));
    fsl_stb_i = 1'b1;
    fsl_wre_i = 1'b0;
    fsl_tag_i = 2'b00;
    repeat (3) tick();
    sys_rst_i = 1'b0;
    #1;
    chk("rstmid_vld", 64'(put_vld_o), 64'(0));
    chk("rstmid_rdy", 64'(get_rdy_o), 64'(0));
    stall_ack = fsl_ack_o;
    repeat (3) begin
      tick();
      stall_ack |= fsl_ack_o;
    end
    fsl_stb_i = 1'b0;
    sys_rst_i = 1'b1;
    chk("rstmid_rdy_hold", 64'(get_rdy_o), 64'(0));
    tick();
    stall_ack |= fsl_ack_o;
    chk("rstmid_no_ack", 64'(stall_ack), 64'(0));
    chk("rstmid_rdy_release", 64'(get_rdy_o), 64'(1));
    chk("rstmid_vld_release", 64'(put_vld_o), 64'(0));

    // Randomised non-blocking traffic against queue model
    do_reset();
    for (int blk = 0; blk < 4; blk++) begin
      for (int it = 0; it < 60; it++) begin
        int r;
        int op;
        r = $urandom_range(0, 9);
        if (blk % 2 == 0) op = (r < 4) ? 0 : (r < 7) ? 3 : (r < 8) ? 1 : 2;
        else              op = (r < 4) ? 2 : (r < 7) ? 1 : (r < 8) ? 0 : 3;
        case (op)
          0: begin
            ent = {1'($urandom_range(0, 1)), 32'($urandom)};
            xfer(1'b1, CHN, {ent[32], 1'b1}, ent[31:0], 5, lat, rdat, rctl);
            chk("rnd_put_lat", 64'(lat), 64'(1));
            if (txq.size() < DEPTH) txq.push_back(ent);
          end
          1: begin
            xfer(1'b0, CHN, {1'($urandom_range(0, 1)), 1'b1}, 32'($urandom), 5, lat, rdat, rctl);
            chk("rnd_get_lat", 64'(lat), 64'(1));
            ent = (rxq.size() != 0) ? rxq.pop_front() : 33'h0;
            chk("rnd_get_dat", 64'(rdat), 64'(ent[31:0]));
            chk("rnd_get_ctl", 64'(rctl), 64'(ent[32]));
          end
          2: begin
            chk("rnd_tx_vld", 64'(put_vld_o), 64'(txq.size() != 0));
            if (txq.size() != 0) begin
              ent = txq.pop_front();
              chk("rnd_tx_dat", 64'(put_dat_o), 64'(ent[31:0]));
              chk("rnd_tx_ctl", 64'(put_ctl_o), 64'(ent[32]));
            end
            put_rdy_i = 1'b1;
            tick();
            put_rdy_i = 1'b0;
          end
          default: begin
            ent = {1'($urandom_range(0, 1)), 32'($urandom)};
            chk("rnd_rx_rdy", 64'(get_rdy_o), 64'(rxq.size() < DEPTH));
            if (rxq.size() < DEPTH) rxq.push_back(ent);
            push_rx(ent[31:0], ent[32]);
          end
        endcase
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
